// File: rtl/timer_pkg.sv
// Shared definitions for the loadable down-timer: state encoding and default width.
package timer_pkg;

  localparam int TIMER_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_EXP   = 2'd3
  } state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter/timer with terminal-count pulse and sticky expired flag.
// Optional DOWN_TIMER_AUTORELOAD_EN: reload the last loaded value on terminal count and keep running.
//
// state   | meaning
// IDLE    | loaded, waiting for start
// RUN     | decrementing on cnt ticks
// PAUSE   | stopped, count held until start
// EXP     | reached zero, sticky until load or reset
import timer_pkg::*;

module down_timer #(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] num,
  input  logic         start,
  input  logic         stop,
  input  logic         cnt,
  output logic [W-1:0] qout,
  output logic         busy,
  output logic         tc,
  output logic         expired
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [W-1:0] qout_q;
  logic         busy_q;
  logic         tc_q;
  logic         expired_q;

`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= num;
    end
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      qout_q    <= '0;
      busy_q    <= 1'b0;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        state_q   <= S_IDLE;
        qout_q    <= num;
        busy_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (qout_q != '0) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end else begin
                state_q   <= S_EXP;
                tc_q      <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // stop outranks a coincident tick, so the paused count is exact
            if (stop) begin
              state_q <= S_PAUSE;
            end else if (cnt) begin
              if (qout_q == ONE) begin
                tc_q <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                qout_q <= reload_q;
`else
                qout_q    <= '0;
                state_q   <= S_EXP;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
`endif
              end else begin
                qout_q <= qout_q - ONE;
              end
            end
          end
          S_PAUSE: begin
            if (start) begin
              state_q <= S_RUN;
            end
          end
          S_EXP: begin
            qout_q <= '0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign qout    = qout_q;
  assign busy    = busy_q;
  assign tc      = tc_q;
  assign expired = expired_q;

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counter/timer; the count-down counterpart to the lab's 3-bit loadable up-counter (same load/num/cnt/clear interface style).
- Software or a parent FSM loads a start value, arms the timer, and feeds count ticks on cnt.
- The block decrements to zero and raises a one-cycle terminal-count pulse plus a sticky expired flag.
- Used as a programmable delay/timeout source beside the up-counter in lab datapaths.

Parameters:
- W, 3, counter width in bits; legal range 2 to 16.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- clr_n, input, 1, asynchronous active-low reset.
- load, input, 1, load num into the counter and force IDLE.
- num, input, W, load value.
- start, input, 1, arm the timer (IDLE to RUN) or resume it (PAUSE to RUN).
- stop, input, 1, pause the timer (RUN to PAUSE).
- cnt, input, 1, count tick; decrement by one when high in RUN.
- qout, output, W, current count (registered).
- busy, output, 1, high in RUN or PAUSE (registered).
- tc, output, 1, one-cycle terminal-count pulse (registered).
- expired, output, 1, sticky flag, high in EXPIRED state.

Behaviour:
- Reset: clock clk; reset clr_n is asynchronous and active-low. On reset: qout=0, busy=0, tc=0, expired=0, state=IDLE.
- States: IDLE, RUN, PAUSE, EXPIRED. Encoding is 2 bits, defined in the package.
- Priority per edge: clr_n > load > start/stop > cnt.
- load, any state: qout<=num, state->IDLE, tc<=0, expired<=0. start, stop and cnt are ignored in the same cycle.
- IDLE:
  - start with qout!=0 -> RUN.
  - start with qout==0 -> EXPIRED, with tc=1 for the next cycle.
  - cnt is ignored.
- RUN:
  - stop -> PAUSE; qout holds. If stop and cnt are both high, stop wins and there is no decrement.
  - cnt with qout>1 -> qout-1.
  - cnt with qout==1 -> qout<=0, state->EXPIRED, tc=1 for exactly one cycle.
  - start is ignored.
- PAUSE:
  - cnt is ignored; qout holds.
  - start -> RUN. If start and stop are both high, start wins.
- EXPIRED:
  - qout holds 0 and expired=1; cnt, stop and start are ignored.
  - Only load or reset leaves this state.
- tc is high for exactly one clock per expiry and is never asserted outside the cycle after the zero transition.
- Latency: qout, busy and expired reflect an input event on the clock edge where that input is sampled (one-cycle registered latency).
- Arithmetic:
  - Modulo-2^W decrement. Underflow is impossible, because RUN never decrements from 0.
  - num=2^W-1 is legal: the timer counts the full range.
- Reset mid-count: immediate asynchronous clear to the reset values above. No residual tc.

Optional Feature:
- Macro: DOWN_TIMER_AUTORELOAD_EN.
- Defined:
  - An extra W-bit reload register captures num on every load (reset value 0).
  - In RUN, cnt with qout==1 sets qout<=reload, state stays RUN, and tc pulses for one cycle. expired is never set by a terminal count in RUN.
  - If reload==0, start from IDLE goes to EXPIRED exactly as without the feature.
- Not defined: no reload register; behaviour exactly as described above (one-shot).

Decomposition:
- Shared package (timer_pkg):
  - 2-bit state typedef/constants: S_IDLE=0, S_RUN=1, S_PAUSE=2, S_EXP=3.
  - Default width constant TIMER_W=3.
- Single module. A separate sub-module is not natural: the datapath is one register plus a decrementer, and the FSM and counter are tightly coupled.

Test Plan:
- Reset: hold clr_n=0 mid-RUN with qout=5 -> qout=0, busy=0, tc=0, expired=0 immediately, without waiting for a clock edge.
- Basic count: load num=3, start, then cnt high for 3 cycles -> qout 3,2,1,0; tc high only in the cycle after qout hits 0; expired=1; busy=0.
- Pause: load 5, start, 2 ticks (qout=3), stop + cnt together -> qout stays 3, busy=1. Then 4 ticks in PAUSE -> qout=3. Then start + 3 ticks -> expires, tc pulses once.
- Zero / full range:
  - load 0, start -> EXPIRED next edge, tc one pulse.
  - load 7 (W=3), start -> 7 ticks to expiry, no wrap.
- Load priority: in EXPIRED, load=1 with start=1 and num=4 -> qout=4, state IDLE, expired=0, busy=0.
- Autoreload (macro defined): load 2, start, cnt held high -> qout 2,1,2,1,...; tc pulses every second tick; expired stays 0.
